// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and default frame constants.
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 10;
  localparam int DATA_BITS_DEF = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer with configurable reset value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q <= RST_VAL;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with valid/ready output and sticky overrun.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif
  rx_state_t state, state_d;
  logic rxd_s, rxd_q, tick, stop, good, par_bad;
  logic [15:0] cnt;
  logic [3:0] bit_cnt;
  logic [DATA_BITS-1:0] shift;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(RXD), .q(rxd_s));

  // START waits half a bit to land mid-bit; later samples are a full bit apart
  assign tick = cnt == (state == START ? HALF : FULL);
  assign stop = state == STOP && tick;
  assign good = stop && rxd_s && !par_bad;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = rxd_q && !rxd_s ? START : IDLE;
      START:   state_d = tick ? (rxd_s ? IDLE : DATA) : START;
      DATA:    state_d = tick && bit_cnt == LAST ? AFTER_DATA : DATA;
      PARITY:  state_d = tick ? STOP : PARITY;
      STOP:    state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rxd_q <= 1'b1;
      cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      rxd_q <= rxd_s;
      cnt <= state == IDLE || tick ? '0 : cnt + 16'd1;
      bit_cnt <= state == IDLE ? '0 : bit_cnt + 4'(state == DATA && tick);
      if (state == DATA && tick) shift <= {rxd_s, shift[DATA_BITS-1:1]};
      frame_err <= stop && !rxd_s;
      if (good) begin
        rx_data <= shift;
        rx_valid <= 1'b1;
        overrun <= overrun || (rx_valid && !rx_ready);
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // par_bad is 1 when data plus parity bit hold an odd number of ones
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && tick) par_bad <= ^{shift, rxd_s};
      parity_err <= stop && par_bad;
    end
  end
`else
  assign par_bad = 1'b0;
  assign parity_err = 1'b0;
`endif
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, meaning clk cycles per serial bit (legal range 4..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..8).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port RXD  input  1  asynchronous serial line; idles high.
REQ-006 SHALL have port rx_data  output  DATA_BITS  last received byte, LSB first on the line.
REQ-007 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts rx_data while rx_valid=1.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  sticky; a new byte arrived while rx_valid=1 and was not consumed.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch.

Function
REQ-012 SHALL pass RXD through a 2-flop synchronizer (reset value 1); all sampling uses the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START on a synchronized high-to-low edge; the bit counter clears.
REQ-015 START samples at count CLKS_PER_BIT/2-1 (integer division): low -> DATA; high -> IDLE (glitch, no outputs).
REQ-016 DATA samples each bit CLKS_PER_BIT cycles after the previous sample and shifts it in LSB first; after DATA_BITS samples, go to PARITY (if enabled) else STOP.
REQ-017 STOP samples once: high -> load rx_data and set rx_valid the next cycle; low -> pulse frame_err, discard the byte, rx_valid unchanged.
REQ-018 STOP -> IDLE immediately after the sample; IDLE SHALL still require a falling edge, so a line held low after a framing error starts no frame.
REQ-019 Handshake: rx_valid stays high with rx_data stable until the cycle after rx_valid&&rx_ready; rx_valid then clears.
REQ-020 Byte completes on the same cycle as acceptance: the new byte loads, rx_valid stays 1, overrun not set.
REQ-021 Byte completes while rx_valid=1 with no acceptance: the new byte overwrites rx_data, rx_valid stays 1, overrun sets.
REQ-022 overrun SHALL clear only on reset.
REQ-023 Latency: rx_valid rises exactly 1 cycle after the stop-bit sample edge.

Reset
REQ-024 rst=1 SHALL force: state IDLE, counters 0, synchronizer 1, rx_data 0, rx_valid 0, frame_err 0, overrun 0, parity_err 0.
REQ-025 rst mid-frame SHALL abort the frame without output; the first frame after release needs a fresh falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit after the data bits; on mismatch, pulse parity_err with the STOP result and do not load the byte.
REQ-027 Macro UART_RX_PARITY_EN undefined: the PARITY state is absent and parity_err is tied to 0.

Structure
REQ-028 Package uart_pkg SHALL hold the rx state enum and the default constants CLKS_PER_BIT_DEF=10 and DATA_BITS_DEF=8.
REQ-029 Sub-module uart_sync2 SHALL implement the 2-flop synchronizer (parameter reset value, default 1).

Verification
REQ-030 10 ns clk, CLKS_PER_BIT=10, rx_ready=1: frame 0,1,1,0,0,0,0,1,0,1 at 100 ns/bit -> rx_data=0x43, rx_valid high 1 cycle, no error flags.
REQ-031 RXD low for 30 ns then high -> START rejects the glitch, no rx_valid, state back in IDLE.
REQ-032 Byte 0xA5 with stop bit 0 -> frame_err pulses 1 cycle, rx_valid stays 0, next valid frame 0x5A received correctly.
REQ-033 rx_ready=0, send 0x11 then 0x22 -> rx_valid stays 1, rx_data=0x22, overrun=1; rx_ready=1 -> rx_valid clears next cycle, overrun stays 1.
REQ-034 rst asserted mid-data of 0xFF then released, send 0x3C -> only 0x3C delivered.
REQ-035 With UART_RX_PARITY_EN, send 0x43 with parity bit 0 (wrong) -> parity_err pulse, no rx_valid; parity bit 1 -> 0x43 delivered.
